// File: rtl/prog_loader_8085.sv
// Byte-stream boot loader: parses SYNC/START/LEN/data/CSUM frames, writes the
// data bytes into instruction memory and releases the core on a good checksum.
//
// state  | meaning
// S_IDLE | hunting for SYNC_BYTE, other bytes dropped
// S_ADDR | next byte is the frame start address
// S_LEN  | next byte is the payload length
// S_DATA | payload bytes, each one written to memory
// S_CSUM | next byte closes the checksum
// S_RUN  | frame loaded, core released; SYNC_BYTE starts a new frame
// S_ERR  | checksum failed, core held; SYNC_BYTE starts a new frame
module prog_loader_8085 #(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [7:0]        i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_im_we,
    output logic [ADDR_W-1:0] o_im_addr,
    output logic [7:0]        o_im_wdata,
    output logic              o_cpu_hold,
    output logic              o_pc_load,
    output logic [ADDR_W-1:0] o_pc_value,
    output logic              o_done,
    output logic              o_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t            r_state;
    logic [7:0]        r_base;
    logic [7:0]        r_len;
    logic [7:0]        r_count;
    logic [7:0]        r_sum;
    logic              r_im_we;
    logic [ADDR_W-1:0] r_im_addr;
    logic [7:0]        r_im_wdata;
    logic              r_cpu_hold;
    logic              r_pc_load;
    logic [ADDR_W-1:0] r_pc_value;
    logic              r_done;
    logic              r_error;

    state_t            w_state;
    logic [7:0]        w_base;
    logic [7:0]        w_len;
    logic [7:0]        w_count;
    logic [7:0]        w_sum;
    logic              w_im_we;
    logic [ADDR_W-1:0] w_im_addr;
    logic [7:0]        w_im_wdata;
    logic              w_cpu_hold;
    logic              w_pc_load;
    logic [ADDR_W-1:0] w_pc_value;
    logic              w_done;
    logic              w_error;

    logic [7:0]        w_sum_byte;
    logic [ADDR_W-1:0] w_wr_addr;

    assign w_sum_byte = r_sum + i_in_data;
    assign w_wr_addr  = ADDR_W'(r_base) + ADDR_W'(r_count);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_count    <= '0;
            r_sum      <= '0;
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
            r_cpu_hold <= 1'b1;
            r_pc_load  <= 1'b0;
            r_pc_value <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_base     <= w_base;
            r_len      <= w_len;
            r_count    <= w_count;
            r_sum      <= w_sum;
            r_im_we    <= w_im_we;
            r_im_addr  <= w_im_addr;
            r_im_wdata <= w_im_wdata;
            r_cpu_hold <= w_cpu_hold;
            r_pc_load  <= w_pc_load;
            r_pc_value <= w_pc_value;
            r_done     <= w_done;
            r_error    <= w_error;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_base     = r_base;
        w_len      = r_len;
        w_count    = r_count;
        w_sum      = r_sum;
        w_im_we    = 1'b0;
        w_im_addr  = r_im_addr;
        w_im_wdata = r_im_wdata;
        w_cpu_hold = r_cpu_hold;
        w_pc_load  = 1'b0;
        w_pc_value = r_pc_value;
        w_done     = r_done;
        w_error    = r_error;

        if (i_in_valid) begin
            case (r_state)
                S_IDLE, S_RUN, S_ERR: begin
                    if (i_in_data == SYNC_BYTE) begin
                        w_state    = S_ADDR;
                        w_cpu_hold = 1'b1;
                        w_done     = 1'b0;
                        w_error    = 1'b0;
                    end
                end
                S_ADDR: begin
                    w_base  = i_in_data;
                    w_sum   = i_in_data;
                    w_state = S_LEN;
                end
                S_LEN: begin
                    w_len   = i_in_data;
                    w_count = '0;
                    w_sum   = w_sum_byte;
                    w_state = (i_in_data == 8'd0) ? S_CSUM : S_DATA;
                end
                S_DATA: begin
                    w_sum      = w_sum_byte;
                    w_im_we    = 1'b1;
                    w_im_addr  = w_wr_addr;
                    w_im_wdata = i_in_data;
                    w_count    = r_count + 8'd1;
                    if (r_count + 8'd1 == r_len) begin
                        w_state = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (w_sum_byte == 8'd0) begin
                        w_state    = S_RUN;
                        w_pc_load  = 1'b1;
                        w_pc_value = ADDR_W'(r_base);
                        w_cpu_hold = 1'b0;
                        w_done     = 1'b1;
                        w_error    = 1'b0;
                    end else begin
                        w_state    = S_ERR;
                        w_cpu_hold = 1'b1;
                        w_done     = 1'b0;
                        w_error    = 1'b1;
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    assign o_in_ready = 1'b1;
    assign o_im_we    = r_im_we;
    assign o_im_addr  = r_im_addr;
    assign o_im_wdata = r_im_wdata;
    assign o_cpu_hold = r_cpu_hold;
    assign o_pc_load  = r_pc_load;
    assign o_pc_value = r_pc_value;
    assign o_done     = r_done;
    assign o_error    = r_error;

endmodule

// File: tb/tb_prog_loader_8085.sv
// Bench for prog_loader_8085: frames are built here, so expected writes and
// outcome come straight from the frame contents and the checksum arithmetic.
module tb_prog_loader_8085;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       im_we;
    logic [7:0] im_addr;
    logic [7:0] im_wdata;
    logic       cpu_hold;
    logic       pc_load;
    logic [7:0] pc_value;
    logic       done;
    logic       error;

    prog_loader_8085 #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_in_data  (in_data),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .o_im_we    (im_we),
        .o_im_addr  (im_addr),
        .o_im_wdata (im_wdata),
        .o_cpu_hold (cpu_hold),
        .o_pc_load  (pc_load),
        .o_pc_value (pc_value),
        .o_done     (done),
        .o_error    (error)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_wq[$];
    logic [7:0]  fr_data[$];
    logic [7:0]  exp_pc    = 8'h00;
    logic [7:0]  last_addr = 8'h00;
    int          prev_res  = 0;
    int          pc_pulses = 0;
    int          exp_pulses = 0;
    logic [15:0] mon_w;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            if (exp_wq.size() == 0) begin
                chk("unexpected_write", 32'(im_we), 32'd0);
            end else begin
                mon_w = exp_wq.pop_front();
                chk("im_addr", 32'(im_addr), 32'(mon_w[15:8]));
                chk("im_wdata", 32'(im_wdata), 32'(mon_w[7:0]));
            end
        end
        if (pc_load === 1'b1) pc_pulses++;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [7:0] frame_sum(input logic [7:0] start);
        logic [7:0] s;
        s = start + 8'(fr_data.size());
        foreach (fr_data[i]) s = s + fr_data[i];
        return s;
    endfunction

    task automatic check_levels();
        chk("done", 32'(done), 32'(prev_res == 1));
        chk("error", 32'(error), 32'(prev_res == 2));
        chk("cpu_hold", 32'(cpu_hold), 32'(prev_res != 1));
        chk("pc_value", 32'(pc_value), 32'(exp_pc));
        chk("in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_im_we", 32'(im_we), 32'd0);
        chk("rst_im_addr", 32'(im_addr), 32'd0);
        chk("rst_im_wdata", 32'(im_wdata), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_pc_load", 32'(pc_load), 32'd0);
        chk("rst_pc_value", 32'(pc_value), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
    endtask

    task automatic gap_send(input logic [7:0] b, input int glo, input int ghi);
        send_byte(b, int'($urandom_range(ghi, glo)));
    endtask

    task automatic run_frame(input logic [7:0] start, input logic [7:0] csum,
                             input int glo, input int ghi, input int n_garbage);
        logic [7:0] s;
        logic [7:0] g;
        bit         good;
        s    = frame_sum(start) + csum;
        good = (s == 8'h00);
        for (int i = 0; i < n_garbage; i++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h5A;
            gap_send(g, glo, ghi);
        end
        if (n_garbage > 0) begin
            @(negedge clk);
            check_levels();
        end
        gap_send(8'hA5, glo, ghi);
        @(negedge clk);
        chk("sync_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("sync_done", 32'(done), 32'd0);
        chk("sync_error", 32'(error), 32'd0);
        gap_send(start, glo, ghi);
        gap_send(8'(fr_data.size()), glo, ghi);
        foreach (fr_data[i]) begin
            exp_wq.push_back({8'(start + 8'(i)), fr_data[i]});
            gap_send(fr_data[i], glo, ghi);
        end
        if (fr_data.size() > 0) last_addr = start + 8'(fr_data.size() - 1);
        gap_send(csum, glo, ghi);
        @(negedge clk);
        chk("pc_load", 32'(pc_load), 32'(good));
        if (good) begin
            exp_pc = start;
            exp_pulses++;
            prev_res = 1;
        end else begin
            prev_res = 2;
        end
        check_levels();
        chk("addr_hold", 32'(im_addr), 32'(last_addr));
        chk("writes_pending", 32'(exp_wq.size()), 32'd0);
        @(negedge clk);
        chk("pc_load_once", 32'(pc_load), 32'd0);
        chk("pc_pulses", 32'(pc_pulses), 32'(exp_pulses));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] st;
        logic [7:0] cs;
        int         len;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;

        fr_data = '{8'h3E, 8'h05, 8'h80};
        run_frame(8'h10, 8'h2A, 0, 0, 0);

        fr_data = '{8'h11, 8'h22, 8'h33};
        run_frame(8'hFE, 8'h99, 0, 1, 0);

        fr_data = '{8'h3E, 8'h05, 8'h80};
        run_frame(8'h10, 8'h2B, 0, 0, 0);
        run_frame(8'h10, 8'h2A, 0, 0, 0);

        fr_data = {};
        send_byte(8'h00, 1);
        send_byte(8'hFF, 1);
        run_frame(8'h20, 8'hE0, 1, 1, 0);

        // interrupted frame: two of three data bytes, then reset
        send_byte(8'hA5, 0);
        send_byte(8'h40, 0);
        send_byte(8'h03, 0);
        exp_wq.push_back({8'h40, 8'h12});
        send_byte(8'h12, 0);
        exp_wq.push_back({8'h41, 8'h34});
        send_byte(8'h34, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset();
        reset = 1'b0;
        exp_wq.delete();
        exp_pc    = 8'h00;
        last_addr = 8'h00;
        prev_res  = 0;
        @(posedge clk);
        #1;
        fr_data = '{8'h3E, 8'h05, 8'h80};
        run_frame(8'h10, 8'h2A, 0, 1, 0);

        fr_data = '{8'h76};
        run_frame(8'h30, 8'h59, 0, 0, 0);

        for (int f = 0; f < 30; f++) begin
            st  = 8'($urandom);
            len = int'($urandom_range(6, 0));
            fr_data = {};
            for (int i = 0; i < len; i++) begin
                fr_data.push_back(($urandom_range(7, 0) == 0) ? 8'hA5 : 8'($urandom));
            end
            cs = 8'h00 - frame_sum(st);
            if ($urandom_range(3, 0) == 0) cs = cs + 8'($urandom_range(255, 1));
            run_frame(st, cs, 0, 2, int'($urandom_range(2, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader_8085.md
Name: prog_loader_8085

Overview:
- Byte-stream program loader for the pipelined 8085 core: the write-side counterpart of the bench's read-side state dump.
- Receives a framed program image over a valid/ready byte interface and writes it into instruction memory.
- Holds the core in stall while loading.
- On a good checksum, loads the PC with the frame's start address and releases the core.
- Replaces hierarchical PC/memory pokes from benches and is the boot path on hardware.

Parameters:
- ADDR_W, 8, instruction-memory address width; addresses wrap modulo 2^ADDR_W.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  8  incoming stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader can accept a byte; a transfer occurs on an edge with in_valid & in_ready
- im_we  output  1  instruction-memory write strobe, one cycle per data byte
- im_addr  output  ADDR_W  write address
- im_wdata  output  8  write data
- cpu_hold  output  1  stall request to the core (1 = frozen)
- pc_load  output  1  one-cycle pulse; the core loads its PC from pc_value
- pc_value  output  ADDR_W  start address of the last accepted frame
- done  output  1  level, last frame loaded successfully
- error  output  1  level, last frame failed its checksum

Behaviour:
- Reset values: in_ready=1, im_we=0, im_addr=0, im_wdata=0, cpu_hold=1, pc_load=0, pc_value=0, done=0, error=0, state=IDLE, count=0, sum=0.
- Reset overrides everything, including mid-frame. Nothing already written is undone. cpu_hold returns to 1.
- in_ready is 1 in every state. The loader never back-pressures.
- Cycles with in_valid=0 change no state; gaps are allowed anywhere in a frame.
- Frame format: SYNC_BYTE, START, LEN, LEN data bytes, CSUM.
- Checksum rule: (START + LEN + sum(data) + CSUM) mod 256 == 0.
- States and transitions, on each accepted byte:
  - IDLE: byte == SYNC_BYTE -> ADDR, set cpu_hold=1, done=0, error=0. Any other byte is discarded.
  - ADDR: latch base=byte, sum=byte -> LEN.
  - LEN: latch len=byte, count=0, sum+=byte. len==0 -> CSUM, else -> DATA.
  - DATA: sum+=byte. Registered write: on the next cycle im_we=1, im_addr=(base+count) mod 2^ADDR_W, im_wdata=byte. count++. After the len-th byte -> CSUM.
  - CSUM: (sum+byte) mod 256 == 0 -> RUN, else -> ERR.
  - RUN: on entry, for exactly one cycle pc_load=1 and pc_value=base; cpu_hold=0 and done=1 from that cycle on. A SYNC_BYTE starts a new frame as in IDLE (cpu_hold=1 the following cycle). Other bytes are ignored.
  - ERR: error=1, cpu_hold stays 1, no pc_load. A SYNC_BYTE restarts as in IDLE; other bytes are ignored.
- Latency:
  - Data byte accepted at edge k -> im_we high during cycle k+1 only.
  - CSUM accepted at edge k -> pc_load, done or error visible in cycle k+1.
- im_we is never high for two consecutive cycles without two accepted data bytes.
- im_addr and im_wdata hold their last values while im_we=0.
- A SYNC_BYTE value inside ADDR/LEN/DATA/CSUM is ordinary payload, not a resync.

Test Plan:
- Basic load: A5,10,03,3E,05,80,2A -> writes IM[0x10]=3E, IM[0x11]=05, IM[0x12]=80 on three single-cycle strobes. Next cycle after CSUM: pc_load=1 for one cycle, pc_value=0x10, cpu_hold=0, done=1, error=0.
- Address wrap: A5,FE,03,11,22,33,99 -> writes at FE, FF, 00. pc_value=0xFE, done=1.
- Bad checksum: A5,10,03,3E,05,80,2B -> three writes still occur; error=1, cpu_hold=1, done=0, no pc_load pulse. Then the basic frame -> error=0, done=1.
- Empty frame and garbage: 00,FF,A5,20,00,E0 with in_valid toggling every other cycle -> leading bytes ignored, no im_we, pc_load with pc_value=0x20.
- Reset mid-frame: reset asserted after 2 of 3 data bytes -> all outputs at reset values. The next complete frame loads correctly, with sum/count not carried over.
- Reload while running: after a successful load send A5,30,01,76,59 -> cpu_hold=1 the cycle after A5 is accepted, IM[0x30]=76, then pc_load with 0x30 and cpu_hold=0.
